// File: rtl/sym_mapper_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sym_mapper_gen
//
// Frame-aware bit-stream to I/Q symbol mapper. IW-bit input words arrive on a
// pipelined Wishbone-style slave port, bit 0 being the oldest bit. Bits are
// gathered in a small buffer and taken 1/2/4/6 at a time (BPSK/QPSK/16QAM/
// 64QAM). Each group is Gray-mapped to signed OW-bit I and Q components,
// which are saturated and presented on a Wishbone-style master port. When
// CYC_I falls the block flushes the remaining bits, optionally zero-padding a
// partial last symbol, and then drops CYC_O.
//
// Handshake semantics (both ports):
//   slave : a word on DAT_I is taken on the rising edge of CLK_I at which
//           CYC_I & STB_I & WE_I & ACK_O are all high. ACK_O is combinational
//           and only rises while the block is running and has room.
//   master: a symbol on DAT_O is taken downstream on the rising edge at which
//           STB_O & ACK_I are both high. While STB_O is high and ACK_I is low,
//           DAT_O and STB_O are held unchanged.
//
// Ports:
//   CLK_I        clock, rising edge
//   RST_I        asynchronous active-low reset
//   DAT_I[IW]    input bit word
//   CYC_I        input frame valid; falling edge ends the frame
//   STB_I, WE_I  input strobe / write enable
//   ACK_O        input word accepted (combinational)
//   DAT_O[2*OW]  {Q, I} output sample
//   CYC_O        output frame active
//   STB_O, WE_O  output symbol valid (WE_O mirrors STB_O)
//   ACK_I        downstream accept
//   STD[2]       01 = WiMAX (bits inverted before mapping), else 802.11
//   modulation select (2 bits): 11 = 64QAM, 10 = 16QAM, 00 = QPSK, 01 = BPSK
//   SYM_CNT_O    symbols emitted in the current frame (saturating)
//   DBG_STATE_O  current FSM state (0 = IDLE, 1 = RUN, 2 = FLUSH)
// -----------------------------------------------------------------------------
module sym_mapper_gen #(
    parameter int              IW        = 8,
    parameter int              OW        = 16,
    parameter logic [OW-1:0]   STEP_BPSK = 16'h7FFF,
    parameter logic [OW-1:0]   STEP_QPSK = 16'h5A82,
    parameter logic [OW-1:0]   STEP_Q16  = 16'h287A,
    parameter logic [OW-1:0]   STEP_Q64  = 16'h13C0,
    parameter bit              PAD_EN    = 1'b1
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [IW-1:0]     DAT_I,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic              WE_I,
    output logic              ACK_O,
    output logic [2*OW-1:0]   DAT_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    input  logic              ACK_I,
    input  logic [1:0]        STD,
    input  logic [1:0]        MOD,
    output logic [15:0]       SYM_CNT_O,
    output logic [1:0]        DBG_STATE_O
);

    // Buffer holds at most 5 leftover bits plus one freshly accepted word.
    localparam int BW = IW + 5;
    localparam int CW = $clog2(IW + 6);

    // Symmetric saturation limits at the widened product width.
    localparam logic signed [OW+3:0] SAT_POS = (OW+4)'((64'd1 << (OW - 1)) - 64'd1);
    localparam logic signed [OW+3:0] SAT_NEG = -SAT_POS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     buf_q, buf_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*OW-1:0]   dat_q, dat_d;
    logic              stb_q, stb_d;
    logic              cyc_q, cyc_d;
    logic [15:0]       sym_cnt_q, sym_cnt_d;
    logic [1:0]        mod_q, mod_d;
    logic [1:0]        std_q, std_d;

    logic [CW-1:0]     k;
    logic              out_free;
    logic              ack;
    logic              active;
    logic              can_consume;
    logic              pad_case;
    logic              emit;
    logic [5:0]        sym_mask;
    logic [5:0]        sym_bits;
    logic [CW-1:0]     cnt_after;
    logic [BW-1:0]     buf_after;

    // -------------------------------------------------------------------------
    // One axis: n Gray-coded bits, b[0] being the MSB of the Gray code.
    // level = 2*gray2bin(g) - (2^n - 1), scaled by the step and saturated.
    // -------------------------------------------------------------------------
    function automatic logic [OW-1:0] map_axis(
        input logic [2:0]    b,
        input logic [1:0]    n,
        input logic [OW-1:0] step
    );
        logic [2:0]              g;
        logic [2:0]              idx;
        logic signed [4:0]       max_lvl;
        logic signed [4:0]       lvl;
        logic signed [OW+3:0]    lvl_w;
        logic signed [OW+3:0]    step_w;
        logic signed [OW+3:0]    prod;
        logic [OW-1:0]           res;
        case (n)
            2'd1: begin
                g       = {2'b00, b[0]};
                max_lvl = 5'sd1;
            end
            2'd2: begin
                g       = {1'b0, b[0], b[1]};
                max_lvl = 5'sd3;
            end
            default: begin
                g       = {b[0], b[1], b[2]};
                max_lvl = 5'sd7;
            end
        endcase
        // Leading zero padding of g leaves the binary value unchanged.
        idx[2] = g[2];
        idx[1] = idx[2] ^ g[1];
        idx[0] = idx[1] ^ g[0];
        lvl    = $signed({1'b0, idx, 1'b0}) - max_lvl;
        lvl_w  = {{(OW-1){lvl[4]}}, lvl};
        step_w = $signed({4'b0000, step});
        prod   = lvl_w * step_w;
        if (prod > SAT_POS) begin
            res = SAT_POS[OW-1:0];
        end else if (prod < SAT_NEG) begin
            res = SAT_NEG[OW-1:0];
        end else begin
            res = prod[OW-1:0];
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Whole symbol: s[0] is the oldest bit. I takes the first half of the
    // symbol bits, Q the second half; BPSK drives Q to zero.
    // -------------------------------------------------------------------------
    function automatic logic [2*OW-1:0] map_sym(
        input logic [5:0] s,
        input logic [1:0] mode
    );
        logic [OW-1:0] i_c;
        logic [OW-1:0] q_c;
        case (mode)
            2'b01: begin
                i_c = map_axis({2'b00, s[0]}, 2'd1, STEP_BPSK);
                q_c = '0;
            end
            2'b00: begin
                i_c = map_axis({2'b00, s[0]}, 2'd1, STEP_QPSK);
                q_c = map_axis({2'b00, s[1]}, 2'd1, STEP_QPSK);
            end
            2'b10: begin
                i_c = map_axis({1'b0, s[1], s[0]}, 2'd2, STEP_Q16);
                q_c = map_axis({1'b0, s[3], s[2]}, 2'd2, STEP_Q16);
            end
            default: begin
                i_c = map_axis({s[2], s[1], s[0]}, 2'd3, STEP_Q64);
                q_c = map_axis({s[5], s[4], s[3]}, 2'd3, STEP_Q64);
            end
        endcase
        return {q_c, i_c};
    endfunction

    // -------------------------------------------------------------------------
    // Bits per symbol for the captured modulation.
    // -------------------------------------------------------------------------
    always_comb begin
        case (mod_q)
            2'b11:   k = CW'(6);
            2'b10:   k = CW'(4);
            2'b00:   k = CW'(2);
            default: k = CW'(1);
        endcase
    end

    // Only bits below cnt are valid; the rest read as zero so a partial
    // symbol at flush is zero-padded before the WiMAX inversion.
    always_comb begin
        sym_mask = '0;
        for (int i = 0; i < 6; i++) begin
            sym_mask[i] = (cnt_q > CW'(i));
        end
    end

    assign sym_bits    = (buf_q[5:0] & sym_mask) ^ {6{std_q == 2'b01}};
    assign out_free    = ~stb_q | ACK_I;
    assign ack         = CYC_I & STB_I & WE_I & (state_q == ST_RUN) & (cnt_q < CW'(6));
    assign active      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign can_consume = active && (cnt_q >= k) && out_free;
    assign pad_case    = (state_q == ST_FLUSH) && (cnt_q != '0) && (cnt_q < k);
    assign emit        = can_consume || (pad_case && (PAD_EN != 1'b0) && out_free);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (CYC_I) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!CYC_I) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Leave only once every bit is gone and the last symbol was taken.
                if ((cnt_q == '0) && !stb_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        dat_d     = dat_q;
        stb_d     = stb_q;
        cyc_d     = cyc_q;
        sym_cnt_d = sym_cnt_q;
        mod_d     = mod_q;
        std_d     = std_q;
        cnt_after = cnt_q;
        buf_after = buf_q;

        // Output register: load a new symbol, retire an accepted one, or hold.
        if (emit) begin
            dat_d = map_sym(sym_bits, mod_q);
            stb_d = 1'b1;
            if (sym_cnt_q != 16'hFFFF) begin
                sym_cnt_d = sym_cnt_q + 16'd1;
            end
        end else if (out_free) begin
            stb_d = 1'b0;
        end

        // Remove consumed bits first, then append any accepted word on top.
        if (can_consume) begin
            cnt_after = cnt_q - k;
            buf_after = buf_q >> k;
        end else if (pad_case && ((PAD_EN == 1'b0) || out_free)) begin
            cnt_after = '0;
            buf_after = '0;
        end

        cnt_d = cnt_after;
        buf_d = buf_after;
        if (ack) begin
            cnt_d = cnt_after + CW'(IW);
            buf_d = buf_after | (BW'(DAT_I) << cnt_after);
        end

        case (state_q)
            ST_IDLE: begin
                if (CYC_I) begin
                    mod_d     = MOD;
                    std_d     = STD;
                    cyc_d     = 1'b1;
                    sym_cnt_d = '0;
                    cnt_d     = '0;
                    buf_d     = '0;
                    stb_d     = 1'b0;
                end
            end
            ST_FLUSH: begin
                if ((cnt_q == '0) && !stb_q) begin
                    cyc_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            buf_q     <= '0;
            cnt_q     <= '0;
            dat_q     <= '0;
            stb_q     <= 1'b0;
            cyc_q     <= 1'b0;
            sym_cnt_q <= '0;
            mod_q     <= 2'b00;
            std_q     <= 2'b00;
        end else begin
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            dat_q     <= dat_d;
            stb_q     <= stb_d;
            cyc_q     <= cyc_d;
            sym_cnt_q <= sym_cnt_d;
            mod_q     <= mod_d;
            std_q     <= std_d;
        end
    end

    assign ACK_O       = ack;
    assign DAT_O       = dat_q;
    assign STB_O       = stb_q;
    assign WE_O        = stb_q;
    assign CYC_O       = cyc_q;
    assign SYM_CNT_O   = sym_cnt_q;
    assign DBG_STATE_O = state_q;

endmodule

// File: tb/tb_sym_mapper_gen.sv
`timescale 1ns/1ps
module tb_sym_mapper_gen;

    localparam int IW = 8;
    localparam int OW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- stimulus / DUT signals ----------------
    logic [IW-1:0]   dat_i;
    logic            cyc_i, stb_i, we_i, ack_i;
    logic [1:0]      std_i, mod_i;

    logic            ack_o, cyc_o, stb_o, we_o;
    logic [2*OW-1:0] dat_o;
    logic [15:0]     sym_cnt_o;
    logic [1:0]      dbg_o;

    logic            ack_np, cyc_np, stb_np, we_np;
    logic [2*OW-1:0] dat_np;
    logic [15:0]     sym_cnt_np;
    logic [1:0]      dbg_np;

    sym_mapper_gen #(.IW(IW), .OW(OW), .PAD_EN(1'b1)) u_dut (
        .CLK_I(clk), .RST_I(rst_n), .DAT_I(dat_i), .CYC_I(cyc_i), .STB_I(stb_i),
        .WE_I(we_i), .ACK_O(ack_o), .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o),
        .WE_O(we_o), .ACK_I(ack_i), .STD(std_i), .MOD(mod_i),
        .SYM_CNT_O(sym_cnt_o), .DBG_STATE_O(dbg_o)
    );

    sym_mapper_gen #(.IW(IW), .OW(OW), .PAD_EN(1'b0)) u_dut_np (
        .CLK_I(clk), .RST_I(rst_n), .DAT_I(dat_i), .CYC_I(cyc_i), .STB_I(stb_i),
        .WE_I(we_i), .ACK_O(ack_np), .DAT_O(dat_np), .CYC_O(cyc_np), .STB_O(stb_np),
        .WE_O(we_np), .ACK_I(ack_i), .STD(std_i), .MOD(mod_i),
        .SYM_CNT_O(sym_cnt_np), .DBG_STATE_O(dbg_np)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [2*OW-1:0] exp_q[$];
    logic [2*OW-1:0] obs_q[$];
    logic [2*OW-1:0] obs_np_q[$];

    // Record every completed output handshake of both instances.
    always @(negedge clk) begin
        if (rst_n && stb_o && ack_i)  obs_q.push_back(dat_o);
        if (rst_n && stb_np && ack_i) obs_np_q.push_back(dat_np);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check(tag, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        end
        exp_q.delete();
        obs_q.delete();
        obs_np_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_frame(input logic [1:0] m, input logic [1:0] s);
        mod_i = m;
        std_i = s;
        cyc_i = 1'b1;
        @(posedge clk); #1;
        // Mode inputs change after capture; the frame must ignore this.
        mod_i = ~m;
        std_i = ~s;
        @(negedge clk);
        check("frame_cyc_o", 64'(cyc_o), 64'd1);
        check("frame_sym_cnt_clr", 64'(sym_cnt_o), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [IW-1:0] w);
        logic got;
        got   = 1'b0;
        dat_i = w;
        stb_i = 1'b1;
        we_i  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ack_o) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_wait", 64'(got), 64'd1);
        @(posedge clk); #1;
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic end_frame();
        logic done;
        done  = 1'b0;
        cyc_i = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!cyc_o && !cyc_np) begin
                done = 1'b1;
                break;
            end
        end
        check("cyc_o_fall", 64'(done), 64'd1);
        check("state_idle", 64'(dbg_o), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [IW-1:0] bp_words [3];
        bp_words[0] = 8'hA5;
        bp_words[1] = 8'h3C;
        bp_words[2] = 8'h0F;

        rst_n = 1'b0;
        dat_i = '0;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b1;
        ack_i = 1'b1;
        std_i = 2'b00;
        mod_i = 2'b00;

        // Reset state, with the slave strobed to show ACK_O stays low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dat_o", 64'(dat_o), 64'd0);
        check("rst_stb_o", 64'(stb_o), 64'd0);
        check("rst_cyc_o", 64'(cyc_o), 64'd0);
        check("rst_sym_cnt", 64'(sym_cnt_o), 64'd0);
        check("rst_ack_o", 64'(ack_o), 64'd0);
        check("rst_state", 64'(dbg_o), 64'd0);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // QPSK 802.11, 0x1B, plus ACK -> STB latency of two cycles.
        start_frame(2'b00, 2'b00);
        send_word(8'h1B);
        @(negedge clk);
        check("lat_t1_stb", 64'(stb_o), 64'd0);
        @(negedge clk);
        check("lat_t2_stb", 64'(stb_o), 64'd1);
        check("lat_t2_we", 64'(we_o), 64'd1);
        check("lat_t2_dat", 64'(dat_o), 64'h5A82_5A82);
        end_frame();
        exp_q.push_back(32'h5A82_5A82);
        exp_q.push_back(32'h5A82_A57E);
        exp_q.push_back(32'hA57E_5A82);
        exp_q.push_back(32'hA57E_A57E);
        check_stream("qpsk");
        check("qpsk_sym_cnt", 64'(sym_cnt_o), 64'd4);

        // 16QAM, 0xB4.
        start_frame(2'b10, 2'b00);
        send_word(8'hB4);
        end_frame();
        exp_q.push_back(32'h796E_8692);
        exp_q.push_back(32'hD786_287A);
        check_stream("q16");
        check("q16_sym_cnt", 64'(sym_cnt_o), 64'd2);

        // 64QAM, 0x01, flush with a 2-bit remainder.
        start_frame(2'b11, 2'b00);
        send_word(8'h01);
        obs_np_q.delete();
        end_frame();
        check("np_count", 64'(obs_np_q.size()), 64'd1);
        if (obs_np_q.size() > 0) check("np_sym0", 64'(obs_np_q[0]), 64'h8001_7FFF);
        check("np_sym_cnt", 64'(sym_cnt_np), 64'd1);
        check("np_state", 64'(dbg_np), 64'd0);
        exp_q.push_back(32'h8001_7FFF);
        exp_q.push_back(32'h8001_8001);
        check_stream("q64_pad");
        check("q64_sym_cnt", 64'(sym_cnt_o), 64'd2);

        // WiMAX QPSK, 0x00 inverted to all ones.
        start_frame(2'b00, 2'b01);
        send_word(8'h00);
        end_frame();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h5A82_5A82);
        check_stream("wimax");

        // BPSK with downstream backpressure.
        start_frame(2'b01, 2'b00);
        send_word(bp_words[0]);
        @(posedge clk); #1;
        ack_i = 1'b0;
        dat_i = bp_words[1];
        stb_i = 1'b1;
        we_i  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_stb_hold", 64'(stb_o), 64'd1);
            check("bp_dat_hold", 64'(dat_o), 64'h0000_7FFF);
            check("bp_ack_low", 64'(ack_o), 64'd0);
            check("bp_ack_low_np", 64'(ack_np), 64'd0);
            @(posedge clk); #1;
        end
        ack_i = 1'b1;
        send_word(bp_words[1]);
        send_word(bp_words[2]);
        end_frame();
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < IW; b++) begin
                exp_q.push_back(bp_words[w][b] ? 32'h0000_7FFF : 32'h0000_8001);
            end
        end
        check_stream("bpsk_bp");
        check("bpsk_sym_cnt", 64'(sym_cnt_o), 64'd24);

        // Asynchronous reset in the middle of a frame.
        start_frame(2'b00, 2'b00);
        send_word(8'hFF);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        cyc_i = 1'b0;
        #1;
        check("arst_stb_o", 64'(stb_o), 64'd0);
        check("arst_cyc_o", 64'(cyc_o), 64'd0);
        check("arst_sym_cnt", 64'(sym_cnt_o), 64'd0);
        check("arst_dat_o", 64'(dat_o), 64'd0);
        check("arst_cnt", 64'(u_dut.cnt_q), 64'd0);
        check("arst_state", 64'(dbg_o), 64'd0);
        obs_q.delete();
        obs_np_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_no_output", 64'(obs_q.size()), 64'd0);
        check("arst_cyc_idle", 64'(cyc_o), 64'd0);
        @(posedge clk); #1;

        // Clean frame after reset; MOD/STD are scrambled after capture.
        start_frame(2'b00, 2'b00);
        send_word(8'h1B);
        end_frame();
        exp_q.push_back(32'h5A82_5A82);
        exp_q.push_back(32'h5A82_A57E);
        exp_q.push_back(32'hA57E_5A82);
        exp_q.push_back(32'hA57E_A57E);
        check_stream("post_rst");
        check("post_rst_sym_cnt", 64'(sym_cnt_o), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sym_mapper_gen.md
Name: sym_mapper_gen

Overview:
- Parametrised, frame-aware successor to the fixed 6-bit symbol mapper.
- Accepts a packed bit stream of IW-bit words on a pipelined Wishbone-style slave port.
- Gathers 1/2/4/6 bits per symbol in an internal bit buffer and Gray-maps them to BPSK/QPSK/16QAM/64QAM I/Q samples of OW bits per component, with saturation.
- Drives a Wishbone-style master port with backpressure and end-of-frame flush/pad; sits between the scrambler/interleaver chain and the IFFT input buffer.

Parameters:
IW, 8, input word width in bits (6..32); bit 0 is the oldest bit.
OW, 16, output component width (signed two's complement).
STEP_BPSK, 16'h7FFF, BPSK amplitude (OW bits).
STEP_QPSK, 16'h5A82, QPSK unit step.
STEP_Q16, 16'h287A, 16QAM unit step.
STEP_Q64, 16'h13C0, 64QAM unit step.
PAD_EN, 1, 1 = zero-pad a partial last symbol at flush; 0 = discard it.

Ports:
CLK_I  in  1  clock, rising edge
RST_I  in  1  reset, asynchronous, active-low
DAT_I  in  IW  input bit word
CYC_I  in  1  frame/cycle valid; falling edge = end of frame
STB_I  in  1  input strobe
WE_I   in  1  write enable
ACK_O  out  1  input word accepted (combinational)
DAT_O  out  2*OW  {Q[OW-1:0], I[OW-1:0]}
CYC_O  out  1  output frame active
STB_O  out  1  output symbol valid
WE_O   out  1  equals STB_O
ACK_I  in  1  downstream accept
STD    in  2  01 = WiMAX (invert bits), others = 802.11
MOD    in  2  11 = 64QAM, 10 = 16QAM, 00 = QPSK, 01 = BPSK
SYM_CNT_O  out  16  symbols emitted in the current frame

Behaviour:
- Reset (RST_I low, async) clears to state IDLE: DAT_O=0, STB_O=0, CYC_O=0, SYM_CNT_O=0, bit count cnt=0, buffer=0. Reset mid-frame drops all buffered bits; no output follows until the next CYC_I rise.
- Mode capture: on the first cycle of IDLE with CYC_I=1, MOD and STD are latched (mod_r, std_r), state goes RUN and CYC_O goes to 1 on the same edge, and SYM_CNT_O is cleared. MOD/STD changes inside a frame are ignored.
- Bits per symbol k from mod_r: 6/4/2/1.
- Bit buffer: width IW+5; cnt range 0..IW+5; new bits are appended at position cnt (after any consume).
- ACK_O = CYC_I & STB_I & WE_I & (state==RUN) & (cnt<6).
- out_free = ~STB_O | ACK_I.
- Consume: when cnt>=k and out_free (state RUN or FLUSH), the low k bits are mapped and registered into DAT_O, STB_O=1, the buffer shifts right by k, cnt-=k and SYM_CNT_O increments (saturating at 16'hFFFF). Consume and accept in the same cycle are legal: cnt_next = cnt-k+IW.
- When out_free and no consume, STB_O->0. When ~out_free, DAT_O and STB_O hold.
- Latency: ACK_O at cycle t gives the first STB_O at t+2.
- Mapping:
  - If std_r==01, symbol bits are inverted before mapping.
  - I axis uses bits s[0..k/2-1]; Q axis uses s[k/2..k-1].
  - Per axis, with n bits: the first bit is the MSB of Gray code g; idx = gray2bin(g); level = 2*idx-(2^n-1).
  - Component = level*STEP_mode, saturated to +/-(2^(OW-1)-1).
  - BPSK: I = s0 ? +STEP_BPSK : -STEP_BPSK, Q = 0.
- FLUSH: entered from RUN when CYC_I=0.
  - Full symbols are emitted as in RUN.
  - When 0<cnt<k: if PAD_EN, one symbol is emitted with the missing bits set to 0 (before STD inversion) and cnt=0; otherwise cnt is cleared with no symbol.
  - When cnt==0 and STB_O==0 (last symbol acked): CYC_O->0 and state goes IDLE. CYC_I reasserting during FLUSH waits until IDLE.
- Arithmetic: products are computed at OW+4 bits, then saturated.

Test Plan:
- QPSK, STD=00, DAT_I=8'h1B -> DAT_O sequence 5A82_5A82, 5A82_A57E, A57E_5A82, A57E_A57E; SYM_CNT_O=4.
- 16QAM, DAT_I=8'hB4 -> 796E_8692 then D786_287A.
- 64QAM, DAT_I=8'h01, then CYC_I drop, PAD_EN=1 -> 8001_7FFF (I=+7 saturated), then padded 8001_8001, then CYC_O falls; with PAD_EN=0, only the first symbol is emitted.
- WiMAX STD=01, QPSK, DAT_I=8'h00 -> four symbols of 5A82_5A82.
- Backpressure: BPSK, 3 words streamed, ACK_I low 3 cycles mid-burst -> DAT_O/STB_O held, ACK_O low while cnt>=6, no symbol lost or duplicated, 24 symbols total at +/-7FFF.
- Async reset mid-frame (RST_I low between edges) -> STB_O, CYC_O, cnt and SYM_CNT_O are 0 immediately; next frame starts clean; MOD change mid-frame has no effect.
